// File: rtl/reg8file_writer_if.sv
// Valid/ready byte stream feeding the register-file write sequencer.
// master drives valid/data, slave returns ready.
interface reg8file_writer_if #(
  parameter int DW = 8
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/reg8file_writer.sv
// Burst write sequencer for the 8x8 register file: one-cycle write latency after each handshake,
// wrapping address; in_ready is high only in WRITE, bubbles simply stall the burst.
module reg8file_writer #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  input  logic          wipe,
  reg8file_writer_if.slave s,
  output logic          rf_clr,
  output logic          rf_en,
  output logic [AW-1:0] rf_wsel,
  output logic [DW-1:0] rf_d,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, WRITE, FIN} state_t;

  localparam logic [AW:0] DEPTH   = (AW+1)'(2**AW);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  state_t        state, state_nxt;
  logic [AW-1:0] addr, addr_nxt;
  logic [AW:0]   cnt, cnt_nxt;
  logic          rf_clr_nxt, rf_en_nxt, done_nxt, err_nxt;
  logic [AW-1:0] rf_wsel_nxt;
  logic [DW-1:0] rf_d_nxt;
  logic          len_ok, hs, last;

  assign len_ok = (len != '0) && (len <= DEPTH);
  assign hs     = s.in_valid && (state == WRITE);
  assign last   = hs && (cnt == CNT_ONE);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= IDLE;
      addr    <= '0;
      cnt     <= '0;
      rf_clr  <= 1'b0;
      rf_en   <= 1'b0;
      rf_wsel <= '0;
      rf_d    <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      addr    <= addr_nxt;
      cnt     <= cnt_nxt;
      rf_clr  <= rf_clr_nxt;
      rf_en   <= rf_en_nxt;
      rf_wsel <= rf_wsel_nxt;
      rf_d    <= rf_d_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
    end
  end

  // wipe outranks start; a start in the same cycle is silently dropped
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!wipe && start && len_ok) state_nxt = WRITE;
      WRITE:   if (last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s.in_ready  = (state == WRITE);
    busy        = (state != IDLE);
    addr_nxt    = addr;
    cnt_nxt     = cnt;
    rf_clr_nxt  = 1'b0;
    err_nxt     = 1'b0;
    rf_en_nxt   = hs;
    done_nxt    = last;
    rf_wsel_nxt = rf_wsel;
    rf_d_nxt    = rf_d;
    if (state == IDLE) begin
      rf_clr_nxt = wipe;
      err_nxt    = !wipe && start && !len_ok;
      if (!wipe && start && len_ok) begin
        addr_nxt = base;
        cnt_nxt  = len;
      end
    end
    if (hs) begin
      rf_wsel_nxt = addr;
      rf_d_nxt    = s.in_data;
      addr_nxt    = addr + 1'b1;
      cnt_nxt     = cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_reg8file_writer.sv
// Bench for reg8file_writer: command table plus burst sequences checked against a write scoreboard
// and a behavioural model of the downstream register file.
module tb_reg8file_writer;

  logic       clk;
  logic       clr;
  logic       start;
  logic [2:0] base;
  logic [3:0] len;
  logic       wipe;
  logic       rf_clr, rf_en, busy, done, err;
  logic [2:0] rf_wsel;
  logic [7:0] rf_d;

  reg8file_writer_if #(.DW(8)) sif ();

  reg8file_writer #(.DW(8), .AW(3)) dut (
    .clk(clk), .clr(clr), .start(start), .base(base), .len(len), .wipe(wipe),
    .s(sif.slave),
    .rf_clr(rf_clr), .rf_en(rf_en), .rf_wsel(rf_wsel), .rf_d(rf_d),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    logic       start;
    logic       wipe;
    logic [3:0] len;
    logic [2:0] base;
    logic       exp_clr;
    logic       exp_err;
  } vec_t;

  wr_t        sb[$];
  logic [7:0] mem [8];
  logic [7:0] bd  [8];
  int         checks = 0;
  int         failures = 0;
  int         done_cnt = 0;
  int         clr_cnt = 0;
  int         err_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // downstream register-file model and write scoreboard
  always @(negedge clk) begin
    wr_t w;
    if (rf_en || rf_clr) check("en_clr_exclusive", {31'd0, rf_en && rf_clr}, 32'd0);
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (rf_clr) begin
      clr_cnt++;
      for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    end
    if (rf_en) begin
      mem[rf_wsel] = rf_d;
      if (sb.size() == 0) begin
        check("unexpected_write", {21'd0, rf_wsel, rf_d}, 32'hFFFF_FFFF);
      end else begin
        w = sb.pop_front();
        check("wr_addr", {29'd0, rf_wsel}, {29'd0, w.a});
        check("wr_data", {24'd0, rf_d}, {24'd0, w.d});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic burst(input logic [2:0] b, input logic [3:0] l, input int bub,
                       input bit wipe_mid, input bit start_mid);
    int d0, c0;
    logic [2:0] a;
    d0 = done_cnt;
    c0 = clr_cnt;
    a  = b;
    start = 1'b1; base = b; len = l; wipe = 1'b0;
    cyc();
    start = 1'b0;
    check("burst_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < int'(l); i++) begin
      check("burst_in_ready", {31'd0, sif.in_ready}, 32'd1);
      sif.in_valid = 1'b1;
      sif.in_data  = bd[i];
      sb.push_back('{a: a, d: bd[i]});
      a = a + 3'd1;
      if (wipe_mid && i == 0) wipe = 1'b1;
      if (start_mid && i == 1) begin
        start = 1'b1; base = 3'd4; len = 4'd1;
      end
      cyc();
      wipe = 1'b0; start = 1'b0; sif.in_valid = 1'b0;
      if (i < int'(l) - 1) begin
        for (int k = 0; k < bub; k++) begin
          check("bubble_busy", {31'd0, busy}, 32'd1);
          cyc();
        end
      end
    end
    check("done_pulse", {31'd0, done}, 32'd1);
    check("done_with_en", {31'd0, rf_en}, 32'd1);
    check("done_wsel", {29'd0, rf_wsel}, {29'd0, b + 3'(l - 4'd1)});
    check("done_in_ready", {31'd0, sif.in_ready}, 32'd0);
    cyc();
    check("post_busy", {31'd0, busy}, 32'd0);
    check("post_done", {31'd0, done}, 32'd0);
    check("done_count", done_cnt - d0, 1);
    check("no_clr_in_burst", clr_cnt - c0, 0);
    check("sb_drained", sb.size(), 0);
  endtask

  vec_t vt[7];

  initial begin
    vt[0] = '{start: 1'b1, wipe: 1'b0, len: 4'd0,  base: 3'd0, exp_clr: 1'b0, exp_err: 1'b1};
    vt[1] = '{start: 1'b1, wipe: 1'b0, len: 4'd9,  base: 3'd2, exp_clr: 1'b0, exp_err: 1'b1};
    vt[2] = '{start: 1'b0, wipe: 1'b1, len: 4'd0,  base: 3'd0, exp_clr: 1'b1, exp_err: 1'b0};
    vt[3] = '{start: 1'b1, wipe: 1'b1, len: 4'd3,  base: 3'd1, exp_clr: 1'b1, exp_err: 1'b0};
    vt[4] = '{start: 1'b1, wipe: 1'b1, len: 4'd0,  base: 3'd0, exp_clr: 1'b1, exp_err: 1'b0};
    vt[5] = '{start: 1'b0, wipe: 1'b0, len: 4'd0,  base: 3'd0, exp_clr: 1'b0, exp_err: 1'b0};
    vt[6] = '{start: 1'b1, wipe: 1'b0, len: 4'd15, base: 3'd7, exp_clr: 1'b0, exp_err: 1'b1};

    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    clr = 1'b0; start = 1'b0; base = '0; len = '0; wipe = 1'b0;
    sif.in_valid = 1'b0; sif.in_data = '0;
    #2;
    check("rst_outputs", {20'd0, sif.in_ready, rf_clr, rf_en, rf_wsel, rf_d, busy, done, err},
          32'd0);
    #8;
    clr = 1'b1;
    cyc();
    check("idle_in_ready", {31'd0, sif.in_ready}, 32'd0);

    // full 8-beat burst from address 0
    for (int i = 0; i < 8; i++) bd[i] = 8'hFF - 8'(i);
    burst(3'd0, 4'd8, 0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) check("readback_full", {24'd0, mem[i]}, {24'd0, 8'hFF - 8'(i)});

    // IDLE command table: wipe / illegal len / wipe+start priority
    for (int v = 0; v < 7; v++) begin
      int e0, c0;
      e0 = err_cnt; c0 = clr_cnt;
      start = vt[v].start; wipe = vt[v].wipe; len = vt[v].len; base = vt[v].base;
      cyc();
      start = 1'b0; wipe = 1'b0;
      check("tbl_clr", {31'd0, rf_clr}, {31'd0, vt[v].exp_clr});
      check("tbl_err", {31'd0, err}, {31'd0, vt[v].exp_err});
      check("tbl_idle", {29'd0, busy, rf_en, sif.in_ready}, 32'd0);
      cyc();
      check("tbl_pulse_end", {30'd0, rf_clr, err}, 32'd0);
      check("tbl_err_count", err_cnt - e0, {31'd0, vt[v].exp_err});
      check("tbl_clr_count", clr_cnt - c0, {31'd0, vt[v].exp_clr});
    end
    for (int i = 0; i < 8; i++) check("readback_wiped", {24'd0, mem[i]}, 32'd0);

    // wrap 6,7,0,1 with two-cycle bubbles
    bd[0] = 8'h11; bd[1] = 8'h22; bd[2] = 8'h33; bd[3] = 8'h44;
    burst(3'd6, 4'd4, 2, 1'b0, 1'b0);
    check("wrap_m6", {24'd0, mem[6]}, 32'h11);
    check("wrap_m1", {24'd0, mem[1]}, 32'h44);

    // wipe ignored during WRITE, then back-to-back start ignored while busy
    bd[0] = 8'h5A;
    burst(3'd7, 4'd1, 0, 1'b1, 1'b0);
    bd[0] = 8'hC0; bd[1] = 8'hC1; bd[2] = 8'hC2;
    burst(3'd0, 4'd3, 1, 1'b1, 1'b1);
    check("wipe_ignored_m7", {24'd0, mem[7]}, 32'h5A);

    // reset mid-burst after two beats
    start = 1'b1; base = 3'd2; len = 4'd5;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sif.in_valid = 1'b1;
      sif.in_data  = 8'hA0 + 8'(i);
      sb.push_back('{a: 3'd2 + 3'(i), d: 8'hA0 + 8'(i)});
      cyc();
    end
    sif.in_valid = 1'b0;
    @(negedge clk);
    #1;
    clr = 1'b0;
    #1;
    check("midrst_outputs", {20'd0, sif.in_ready, rf_clr, rf_en, rf_wsel, rf_d, busy, done, err},
          32'd0);
    cyc();
    clr = 1'b1;
    sif.in_valid = 1'b1; sif.in_data = 8'hEE;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("midrst_no_ready", {30'd0, sif.in_ready, busy}, 32'd0);
    end
    sif.in_valid = 1'b0;
    cyc();
    check("midrst_sb", sb.size(), 0);
    check("midrst_m2", {24'd0, mem[2]}, 32'hA0);
    check("midrst_m3", {24'd0, mem[3]}, 32'hA1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg8file_writer.md
Name: reg8file_writer

Overview:
- Upstream write sequencer for the 8x8 register file.
- Accepts a burst command (base address, length) and a valid/ready byte stream, then drives the register file's en/wsel/d write port with an auto-incrementing, wrapping address.
- Also issues a one-cycle clear pulse to the register file on a wipe command.
- Outputs connect directly to reg8file's clr/en/wsel/d inputs.

Parameters:
- DW, 8, data width of stream bytes and register-file write data
- AW, 3, register-file address width (DEPTH = 2**AW = 8)

Ports:
- clk  in  1  system clock, rising-edge
- clr  in  1  asynchronous, active-low reset (clr=0 resets)
- start  in  1  burst command strobe, sampled in IDLE only
- base  in  AW  first register address of burst
- len  in  AW+1  burst length in beats, legal 1..DEPTH
- wipe  in  1  register-file clear command, sampled in IDLE only
- in_valid  in  1  stream byte valid
- in_data  in  DW  stream byte
- in_ready  out  1  writer can accept a byte
- rf_clr  out  1  active-high clear to register file
- rf_en  out  1  register-file write enable
- rf_wsel  out  AW  register-file write address
- rf_d  out  DW  register-file write data
- busy  out  1  burst in progress (state != IDLE)
- done  out  1  one-cycle pulse, burst complete
- err  out  1  one-cycle pulse, illegal len rejected

Behaviour:
- Reset (clr=0, async): state=IDLE; addr=0; cnt=0; all outputs 0 (in_ready, rf_clr, rf_en, rf_wsel, rf_d, busy, done, err). Reset mid-burst aborts it; no further rf_en until a new start.
- All outputs are registered except in_ready and busy, which decode state directly.
- State IDLE:
  - in_ready=0.
  - wipe=1 -> rf_clr=1 for exactly the next cycle; stay IDLE. wipe has priority over start in the same cycle; that start is dropped with no err.
  - start=1 with len in 1..DEPTH -> latch addr=base, cnt=len; go WRITE.
  - start=1 with len=0 or len>DEPTH -> err=1 for the next cycle; stay IDLE.
- State WRITE:
  - in_ready=1. start and wipe are ignored.
  - Handshake when in_valid & in_ready at edge k. During cycle k+1: rf_en=1, rf_wsel=addr, rf_d=in_data (one-cycle write latency).
  - On each handshake, addr = addr+1 modulo DEPTH (7 wraps to 0) and cnt = cnt-1.
  - in_valid=0 inserts bubbles: rf_en=0 in the following cycle, state held, no timeout.
  - Handshake with cnt==1 -> go DONE.
- State DONE:
  - in_ready=0. done=1 during this cycle, which coincides with the final rf_en=1 cycle.
  - Unconditionally return to IDLE at the next edge; busy=0 from then.
- rf_en is never high in the same cycle as rf_clr.
- Back-to-back bursts: earliest new start is sampled in the first IDLE cycle after DONE.
- rf_wsel and rf_d hold their last values when rf_en=0.
- Arithmetic: address increment truncates to AW bits; cnt is AW+1 bits, so len=8 is representable and the counter never underflows.

Test Plan:
- Reset then full burst: clr low 10 ns then high; start with base=0, len=8; stream 0xFF..0xF8 with in_valid held -> rf_en high 8 consecutive cycles, rf_wsel 0..7, rf_d 0xFF..0xF8; done in the 8th write cycle; busy low afterwards; readback via reg8file rsel 0..7 gives 0xFF..0xF8.
- Wrap and bubbles: base=6, len=4, data 0x11,0x22,0x33,0x44 with in_valid low for 2 cycles between beats -> writes to addresses 6,7,0,1 with matching data; rf_en low during bubbles; single done pulse.
- Illegal length: start with len=0, then len=9 -> err pulses once per command; busy and rf_en stay 0; in_ready stays 0.
- Wipe handling: wipe in IDLE -> rf_clr high exactly 1 cycle and reg8file reads all 0x00. wipe and start asserted together -> only rf_clr; busy stays 0. wipe during WRITE -> ignored, burst completes normally.
- Reset mid-burst: base=2, len=5, accept 2 beats (0xA0, 0xA1), then assert clr -> all outputs 0 immediately (asynchronous); after release, no rf_en without a new start; registers 2 and 3 hold 0xA0 and 0xA1.
- Command while busy: second start (base=4, len=1) during WRITE -> ignored; first burst's addresses and length are unaffected.
